fp_to_fixed_pipe: RTL and testbench

- Pipelined IEEE-754 single-precision to signed fixed-point converter. It is the reverse path of the LZD-based fixed-to-float normaliser that feeds the exponential unit.
- Takes fp32 results (e.g. exp outputs) and returns them to the fixed-point domain: Q(OUT_W-FRAC_BITS).FRAC_BITS two's complement, for the accumulate/divide stages of softmax.
- 3-stage pipeline with valid/ready flow control and per-result status flags.

---
 rtl/fx_fp_pkg.sv | 43 ++++
 rtl/fx_round_shift.sv | 61 ++++++
 rtl/fp_to_fixed_pipe.sv | 188 ++++++++++++++++++
 tb/tb_fp_to_fixed_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx_fp_pkg.sv
// rtl/fx_fp_pkg.sv - shared fp32 field layout, status bit indices and stage types
package fx_fp_pkg;

    // fp32 field layout
    localparam int FP_W        = 32;
    localparam int FP_FRAC_W   = 23;
    localparam int FP_EXP_W    = 8;
    localparam int FP_MANT_W   = FP_FRAC_W + 1;
    localparam int FP_FRAC_LSB = 0;
    localparam int FP_EXP_LSB  = FP_FRAC_W;
    localparam int FP_SIGN_BIT = FP_W - 1;
    localparam int FP_BIAS     = 127;

    // all-ones exponent marks Inf/NaN
    localparam logic [FP_EXP_W-1:0] FP_EXP_SPECIAL = '1;

    // status vector bit positions, common to both conversion directions
    localparam int ST_W       = 4;
    localparam int ST_INVALID = 3;
    localparam int ST_INF     = 2;
    localparam int ST_OVF     = 1;
    localparam int ST_INEXACT = 0;

    // signed shift-amount width; covers every exponent for any sane FRAC_BITS
    localparam int SH_W = 10;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NUM  = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_e;

    // unpacked operand as held in the first pipeline stage
    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
        fp_class_e            cls;
        logic                 inexact;
    } s1_payload_t;

endpackage

// File: rtl/fx_round_shift.sv
// rtl/fx_round_shift.sv - signed-amount barrel shift with round-to-nearest-even
module fx_round_shift
    import fx_fp_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic [FP_MANT_W-1:0]   mant,
    input  logic signed [SH_W-1:0] sh,
    output logic [OUT_W:0]         mag,
    output logic                   inexact,
    output logic                   ovf
);

    localparam int MAG_W = OUT_W + 1;
    // largest left shift that keeps the mantissa inside OUT_W bits
    localparam logic signed [SH_W-1:0] LSH_MAX = SH_W'(OUT_W - FP_MANT_W);
    // right shifts from here on leave neither kept bits nor a guard bit
    localparam logic [SH_W-1:0] RSH_ZERO = SH_W'(FP_MANT_W + 1);

    logic [MAG_W-1:0]       mant_ext;
    logic [SH_W-1:0]        rsh;
    logic [2*FP_MANT_W-1:0] wide;
    logic [FP_MANT_W-1:0]   kept;
    logic                   guard;
    logic                   sticky;
    logic                   round_up;

    // positive amounts shift left and flag overflow; negative amounts shift right and round RNE
    always_comb begin
        mant_ext = MAG_W'(mant);
        rsh      = SH_W'(-sh);
        wide     = '0;
        kept     = '0;
        guard    = 1'b0;
        sticky   = 1'b0;
        round_up = 1'b0;
        mag      = '0;
        inexact  = 1'b0;
        ovf      = 1'b0;
        if (!sh[SH_W-1]) begin
            if (sh > LSH_MAX) begin
                ovf = 1'b1;
            end else begin
                mag = mant_ext << sh;
            end
        end else if (rsh >= RSH_ZERO) begin
            inexact = |mant;
        end else begin
            // lower half of the wide word collects the discarded bits
            wide     = {mant, {FP_MANT_W{1'b0}}} >> rsh;
            kept     = wide[2*FP_MANT_W-1:FP_MANT_W];
            guard    = wide[FP_MANT_W-1];
            sticky   = |wide[FP_MANT_W-2:0];
            inexact  = guard | sticky;
            round_up = guard & (sticky | kept[0]);
            // the extra magnitude bit absorbs a rounding carry-out
            mag      = MAG_W'(kept) + MAG_W'(round_up);
        end
    end

endmodule

// File: rtl/fp_to_fixed_pipe.sv
// rtl/fp_to_fixed_pipe.sv - 3-stage fp32 to signed fixed-point converter with valid/ready
module fp_to_fixed_pipe
    import fx_fp_pkg::*;
#(
    parameter int OUT_W     = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] z,
    output logic [ST_W-1:0]  status
);

    // shift that turns the integer mantissa into an LSB-aligned fixed-point magnitude
    localparam logic signed [SH_W-1:0] SH_OFS = SH_W'(FRAC_BITS - FP_FRAC_W - FP_BIAS);

    localparam logic [OUT_W:0]   POS_LIMIT = {2'b00, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W:0]   NEG_LIMIT = {2'b01, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] Z_MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] Z_MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    logic adv;

    // stage 1: unpacked operand
    logic        s1_valid_q, s1_valid_d;
    s1_payload_t s1_q, s1_d;

    // stage 2: aligned and rounded magnitude
    logic          s2_valid_q, s2_valid_d;
    logic          s2_sign_q, s2_sign_d;
    fp_class_e     s2_cls_q, s2_cls_d;
    logic [OUT_W:0] s2_mag_q, s2_mag_d;
    logic          s2_inexact_q, s2_inexact_d;
    logic          s2_ovf_q, s2_ovf_d;

    // stage 3: output register
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] z_q, z_d;
    logic [ST_W-1:0]  status_q, status_d;

    // shifter interface
    logic signed [SH_W-1:0] s2_sh;
    logic [OUT_W:0]         rs_mag;
    logic                   rs_inexact;
    logic                   rs_ovf;

    logic [FP_EXP_W-1:0]  in_exp;
    logic [FP_FRAC_W-1:0] in_frac;

    // one enable for the whole pipe: move whenever the output slot is free or draining
    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign z         = z_q;
    assign status    = status_q;

    assign in_exp  = a[FP_EXP_LSB +: FP_EXP_W];
    assign in_frac = a[FP_FRAC_LSB +: FP_FRAC_W];

    // stage 1: split fields and classify zero/denormal, Inf, NaN, finite
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (adv) begin
            s1_valid_d   = in_valid;
            s1_d.sign    = a[FP_SIGN_BIT];
            s1_d.exp     = in_exp;
            s1_d.mant    = {1'b1, in_frac};
            s1_d.inexact = 1'b0;
            if (in_exp == '0) begin
                // denormals flush to zero; only a nonzero fraction loses value
                s1_d.cls     = CLS_ZERO;
                s1_d.inexact = |in_frac;
            end else if (in_exp == FP_EXP_SPECIAL) begin
                s1_d.cls = (|in_frac) ? CLS_NAN : CLS_INF;
            end else begin
                s1_d.cls = CLS_NUM;
            end
        end
    end

    assign s2_sh = $signed({{(SH_W-FP_EXP_W){1'b0}}, s1_q.exp}) + SH_OFS;

    fx_round_shift #(
        .OUT_W (OUT_W)
    ) u_round_shift (
        .mant    (s1_q.mant),
        .sh      (s2_sh),
        .mag     (rs_mag),
        .inexact (rs_inexact),
        .ovf     (rs_ovf)
    );

    // stage 2: take the shifter result for finite operands, pass classes through
    always_comb begin
        s2_valid_d   = s2_valid_q;
        s2_sign_d    = s2_sign_q;
        s2_cls_d     = s2_cls_q;
        s2_mag_d     = s2_mag_q;
        s2_inexact_d = s2_inexact_q;
        s2_ovf_d     = s2_ovf_q;
        if (adv) begin
            s2_valid_d = s1_valid_q;
            s2_sign_d  = s1_q.sign;
            s2_cls_d   = s1_q.cls;
            if (s1_q.cls == CLS_NUM) begin
                s2_mag_d     = rs_mag;
                s2_inexact_d = rs_inexact;
                s2_ovf_d     = rs_ovf;
            end else begin
                s2_mag_d     = '0;
                s2_inexact_d = s1_q.inexact;
                s2_ovf_d     = 1'b0;
            end
        end
    end

    // stage 3: apply sign, saturate against the asymmetric two's-complement range, set flags
    always_comb begin
        out_valid_d = out_valid_q;
        z_d         = z_q;
        status_d    = status_q;
        if (adv) begin
            out_valid_d = s2_valid_q;
            z_d         = '0;
            status_d    = '0;
            case (s2_cls_q)
                CLS_NAN: begin
                    z_d                 = Z_MAX_POS;
                    status_d[ST_INVALID] = 1'b1;
                end
                CLS_INF: begin
                    z_d             = s2_sign_q ? Z_MIN_NEG : Z_MAX_POS;
                    status_d[ST_INF] = 1'b1;
                end
                CLS_ZERO: begin
                    status_d[ST_INEXACT] = s2_inexact_q;
                end
                default: begin
                    if (s2_ovf_q ||
                        (!s2_sign_q && (s2_mag_q > POS_LIMIT)) ||
                        ( s2_sign_q && (s2_mag_q > NEG_LIMIT))) begin
                        z_d             = s2_sign_q ? Z_MIN_NEG : Z_MAX_POS;
                        status_d[ST_OVF] = 1'b1;
                    end else begin
                        z_d                  = s2_sign_q ? OUT_W'(-s2_mag_q) : s2_mag_q[OUT_W-1:0];
                        status_d[ST_INEXACT] = s2_inexact_q;
                    end
                end
            endcase
        end
    end

    // pipeline registers; reset discards everything in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q   <= 1'b0;
            s1_q         <= '0;
            s2_valid_q   <= 1'b0;
            s2_sign_q    <= 1'b0;
            s2_cls_q     <= CLS_ZERO;
            s2_mag_q     <= '0;
            s2_inexact_q <= 1'b0;
            s2_ovf_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            z_q          <= '0;
            status_q     <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_q         <= s1_d;
            s2_valid_q   <= s2_valid_d;
            s2_sign_q    <= s2_sign_d;
            s2_cls_q     <= s2_cls_d;
            s2_mag_q     <= s2_mag_d;
            s2_inexact_q <= s2_inexact_d;
            s2_ovf_q     <= s2_ovf_d;
            out_valid_q  <= out_valid_d;
            z_q          <= z_d;
            status_q     <= status_d;
        end
    end

endmodule

// File: tb/tb_fp_to_fixed_pipe.sv
// tb/tb_fp_to_fixed_pipe.sv - self-checking bench for fp_to_fixed_pipe
module tb_fp_to_fixed_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z;
    logic [3:0]  status;

    fp_to_fixed_pipe #(
        .OUT_W     (32),
        .FRAC_BITS (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .status    (status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] z;
        logic [3:0]  st;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] z;
        logic [3:0]  st;
    } vec_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          delivered = 0;
    logic        lat_chk = 1'b0;
    logic        acc = 1'b0;
    logic [31:0] cur_z = '0;
    logic [3:0]  cur_st = '0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_z = '0;
    logic [3:0]  prev_st = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // value scaled by 2^16, rounded to nearest even, then range-checked as a signed integer
    function automatic void ref_conv(input logic [31:0] x, output logic [31:0] rz, output logic [3:0] rst);
        int     e;
        int     n;
        longint m;
        longint q;
        longint rem;
        longint half;
        longint v;
        logic   s;
        logic   inx;
        s   = x[31];
        e   = int'(x[30:23]);
        m   = longint'(x[22:0]);
        rz  = '0;
        rst = '0;
        inx = 1'b0;
        if (e == 0) begin
            rst[0] = (m != 0);
            return;
        end
        if (e == 255) begin
            if (m != 0) begin
                rz  = 32'h7FFF_FFFF;
                rst = 4'b1000;
            end else begin
                rz  = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
                rst = 4'b0100;
            end
            return;
        end
        m = m + (64'sd1 << 23);
        n = e - 127 - 23 + 16;
        if (n >= 0) begin
            q = (n > 30) ? (64'sd1 << 40) : (m << n);
        end else begin
            n = -n;
            if (n > 40) begin
                q   = 0;
                inx = 1'b1;
            end else begin
                q    = m >> n;
                rem  = m - (q << n);
                half = 64'sd1 << (n - 1);
                if (rem > half || (rem == half && q[0])) q = q + 1;
                inx = (rem != 0);
            end
        end
        v = s ? -q : q;
        if (v > 64'sd2147483647 || v < -64'sd2147483648) begin
            rz  = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            rst = 4'b0010;
        end else begin
            rz     = v[31:0];
            rst[0] = inx;
        end
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        int         sel;
        sel = $urandom_range(0, 19);
        if (sel < 3) return $urandom();
        if (sel == 3) e = 8'h00;
        else if (sel == 4) e = 8'hFF;
        else e = 8'($urandom_range(100, 145));
        return {1'($urandom_range(0, 1)), e, 23'($urandom())};
    endfunction

    // one cycle: sample at negedge, score handshakes, then resume just after the next posedge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        check("in_ready_rule", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
        if (prev_stall) begin
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_z", {32'd0, z}, {32'd0, prev_z});
            check("hold_status", {60'd0, status}, {60'd0, prev_st});
        end
        prev_stall = out_valid && !out_ready;
        prev_z     = z;
        prev_st    = status;
        acc = in_valid && in_ready;
        if (acc) begin
            e.z   = cur_z;
            e.st  = cur_st;
            e.cyc = cyc;
            sb.push_back(e);
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got z=%h with nothing pending, expected no output", z);
            end else begin
                e = sb.pop_front();
                check("z", {32'd0, z}, {32'd0, e.z});
                check("status", {60'd0, status}, {60'd0, e.st});
                if (lat_chk) check("latency", 64'(cyc - e.cyc), 64'd3);
                delivered++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[18];
        logic [31:0] ops[8];
        logic        ov_hist[8];
        logic        pat[4];
        logic        want_ov[8];
        int          k;
        int          d0;
        logic        saw_block;

        vecs[0]  = '{32'h3F80_0000, 32'h0001_0000, 4'b0000};
        vecs[1]  = '{32'hC020_0000, 32'hFFFD_8000, 4'b0000};
        vecs[2]  = '{32'h3740_0000, 32'h0000_0001, 4'b0001};
        vecs[3]  = '{32'h3700_0000, 32'h0000_0000, 4'b0001};
        vecs[4]  = '{32'h4780_0000, 32'h7FFF_FFFF, 4'b0010};
        vecs[5]  = '{32'hC700_0000, 32'h8000_0000, 4'b0000};
        vecs[6]  = '{32'hFF80_0000, 32'h8000_0000, 4'b0100};
        vecs[7]  = '{32'h7FC0_0000, 32'h7FFF_FFFF, 4'b1000};
        vecs[8]  = '{32'h3F40_0000, 32'h0000_C000, 4'b0000};
        vecs[9]  = '{32'h37C0_0000, 32'h0000_0002, 4'b0001};
        vecs[10] = '{32'h46FF_FFFE, 32'h7FFF_FF00, 4'b0000};
        vecs[11] = '{32'h4700_0000, 32'h7FFF_FFFF, 4'b0010};
        vecs[12] = '{32'hC700_0001, 32'h8000_0000, 4'b0010};
        vecs[13] = '{32'h7F80_0000, 32'h7FFF_FFFF, 4'b0100};
        vecs[14] = '{32'h8000_0000, 32'h0000_0000, 4'b0000};
        vecs[15] = '{32'h8000_0001, 32'h0000_0000, 4'b0001};
        vecs[16] = '{32'h3380_0000, 32'h0000_0000, 4'b0001};
        vecs[17] = '{32'h3F7F_FFFF, 32'h0001_0000, 4'b0001};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_z", {32'd0, z}, 64'd0);
        check("rst_status", {60'd0, status}, 64'd0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // directed vectors, one at a time, with exact-latency checking
        lat_chk = 1'b1;
        for (int i = 0; i < 18; i++) begin
            a        = vecs[i].a;
            cur_z    = vecs[i].z;
            cur_st   = vecs[i].st;
            in_valid = 1'b1;
            tick();
            check("vec_accept", {63'd0, acc}, 64'd1);
            in_valid = 1'b0;
            repeat (4) tick();
        end
        drain();
        lat_chk = 1'b0;

        // random operands with random valid and backpressure against the model
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            a         = rand_fp();
            ref_conv(a, cur_z, cur_st);
            tick();
        end
        drain();

        // 8 back-to-back operands with the output stalled for cycles 4..9
        for (int i = 0; i < 8; i++) ops[i] = rand_fp();
        k         = 0;
        d0        = delivered;
        saw_block = 1'b0;
        for (int c = 0; c < 60 && (delivered - d0) < 8; c++) begin
            out_ready = !(c >= 4 && c <= 9);
            in_valid  = (k < 8);
            if (k < 8) begin
                a = ops[k];
                ref_conv(a, cur_z, cur_st);
            end
            if (!in_ready && out_valid) saw_block = 1'b1;
            tick();
            if (acc) k++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stall_in_ready_dropped", {63'd0, saw_block}, 64'd1);
        check("stall_delivered", 64'(delivered - d0), 64'd8);
        check("stall_queue_empty", 64'(sb.size()), 64'd0);

        // bubbles propagate: 1,0,1,0 in gives 1,0,1,0 out three cycles later
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0;
        for (int i = 0; i < 8; i++) want_ov[i] = (i >= 2 && i <= 5) ? pat[i-2] : 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i < 4) ? pat[i] : 1'b0;
            a        = rand_fp();
            ref_conv(a, cur_z, cur_st);
            tick();
            ov_hist[i] = out_valid;
        end
        for (int i = 0; i < 8; i++) check($sformatf("bubble_ov_%0d", i), {63'd0, ov_hist[i]}, {63'd0, want_ov[i]});
        drain();

        // asynchronous reset with three operands in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = vecs[i].a;
            ref_conv(a, cur_z, cur_st);
            tick();
        end
        in_valid = 1'b0;
        check("pre_reset_valid", {63'd0, out_valid}, 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_valid", {63'd0, out_valid}, 64'd0);
        check("async_rst_z", {32'd0, z}, 64'd0);
        check("async_rst_status", {60'd0, status}, 64'd0);
        sb.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("no_stale_valid", {63'd0, out_valid}, 64'd0);
        end
        lat_chk  = 1'b1;
        a        = 32'h3F80_0000;
        cur_z    = 32'h0001_0000;
        cur_st   = 4'b0000;
        in_valid = 1'b1;
        tick();
        check("post_rst_accept", {63'd0, acc}, 64'd1);
        drain();
        lat_chk = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
